// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline decode stage: opcode/funct constants,
// ALUOp, branch, MemToReg and PCSrc encodings, and the IDEX bundle layout.
package pipeline_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int IDEX_W = 160;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  // ALUOp when Branch = 0
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_ADDU  = 4'd1;
  localparam logic [3:0] ALU_SUB   = 4'd2;
  localparam logic [3:0] ALU_SUBU  = 4'd3;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_OR    = 4'd5;
  localparam logic [3:0] ALU_XOR   = 4'd6;
  localparam logic [3:0] ALU_NOR   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_SLL   = 4'd10;
  localparam logic [3:0] ALU_SRL   = 4'd11;
  localparam logic [3:0] ALU_SRA   = 4'd12;
  localparam logic [3:0] ALU_PASSB = 4'd13;

  // ALUOp when Branch = 1: the condition EX evaluates
  localparam logic [3:0] BR_EQ  = 4'd0;
  localparam logic [3:0] BR_NE  = 4'd1;
  localparam logic [3:0] BR_LEZ = 4'd2;
  localparam logic [3:0] BR_GTZ = 4'd3;

  // MemToReg
  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_PC4 = 2'd2;

  // PCSrc
  localparam logic [2:0] PC_SEQ    = 3'd0;
  localparam logic [2:0] PC_BRANCH = 3'd1;
  localparam logic [2:0] PC_JT     = 3'd2;
  localparam logic [2:0] PC_REG    = 3'd3;

  // IDEX field bit positions (LSB of each field)
  localparam int IDEX_PC4_LSB      = 128;
  localparam int IDEX_BUSA_LSB     = 96;
  localparam int IDEX_BUSB_LSB     = 64;
  localparam int IDEX_IMM_LSB      = 32;
  localparam int IDEX_RS_LSB       = 27;
  localparam int IDEX_RT_LSB       = 22;
  localparam int IDEX_DST_LSB      = 17;
  localparam int IDEX_SHAMT_LSB    = 12;
  localparam int IDEX_REGWRITE     = 11;
  localparam int IDEX_MEMREAD      = 10;
  localparam int IDEX_MEMWRITE     = 9;
  localparam int IDEX_MEMTOREG_LSB = 7;
  localparam int IDEX_ALUSRCA      = 6;
  localparam int IDEX_ALUSRCB      = 5;
  localparam int IDEX_BRANCH       = 4;
  localparam int IDEX_ALUOP_LSB    = 0;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       branch;
    logic [3:0] alu_op;
  } ctrl_t;

  // Packed order matches the IDEX bit positions above, MSB first.
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [4:0]  shamt;
    ctrl_t       ctrl;
  } idex_t;

  // andi/ori zero-extend, lui shifts into the upper half, all else sign-extends.
  function automatic logic [31:0] ext_imm(input logic [5:0] op, input logic [15:0] imm16);
    logic [31:0] r;
    case (op)
      OP_ANDI, OP_ORI: r = {16'h0000, imm16};
      OP_LUI:          r = {imm16, 16'h0000};
      default:         r = {{16{imm16[15]}}, imm16};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipeline_regfile.sv
// 32x32 register file, two combinational read ports, one write port.
// $0 reads as zero and ignores writes. Optional feature macro:
// REGFILE_BYPASS_EN - a read of the register being written this cycle
// returns the write data.
module pipeline_regfile
  import pipeline_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic [XLEN-1:0]   rd_data_a,
  output logic [XLEN-1:0]   rd_data_b
);

  logic [XLEN-1:0] regs [32];

  // Register array: cleared by reset, written on the clock edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports, with same-cycle write data forwarded when the bypass is built in
  always_comb begin
    rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wr_addr != '0) && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
    if (wr_en && (wr_addr != '0) && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
`endif
  end

endmodule

// File: rtl/pipeline_id_stage.sv
// Instruction-decode stage: decodes IFID, reads the register file, detects
// load-use / jump-register / writeback hazards, resolves j/jal/jr/jalr and
// registers the IDEX bundle. Optional feature macro: REGFILE_BYPASS_EN
// (regfile write-then-read bypass; without it a pending writeback to a
// source register stalls decode for one cycle).
//
// Flow control: Stall is combinational and tells fetch to hold PC and IFID
// this cycle; while Stall is high a bubble enters IDEX. nop squashes the
// current decode (bubble into IDEX) and beats Stall; Stall is still driven
// but fetch ignores it. A jump only takes effect (PCSrc != 0, IDnop = 1)
// in a cycle with neither Stall nor nop.
module pipeline_id_stage
  import pipeline_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   IFID,
  input  logic          nop,
  input  logic          wb_en,
  input  logic [4:0]    wb_addr,
  input  logic [31:0]   wb_data,
  input  logic          mem_regwrite,
  input  logic [4:0]    mem_dst,
  output logic          Stall,
  output logic          IDnop,
  output logic [2:0]    PCSrc,
  output logic [25:0]   JT,
  output logic [31:0]   DatabusA,
  output logic [159:0]  IDEX
);

  logic [31:0] instr;
  logic [31:0] pc4;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;

  assign pc4   = IFID[63:32];
  assign instr = IFID[31:0];
  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];

  logic [31:0] bus_a;
  logic [31:0] bus_b;

  pipeline_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data),
    .rd_addr_a (rs),
    .rd_addr_b (rt),
    .rd_data_a (bus_a),
    .rd_data_b (bus_b)
  );

  ctrl_t       ctrl;
  logic [4:0]  dst;
  logic        reads_rs;
  logic        rt_used;
  logic        is_jump;
  logic        is_jreg;
  idex_t       idex_q;
  idex_t       idex_d;

  // Control decode; anything not recognised leaves all ctrl bits clear
  always_comb begin
    ctrl     = '0;
    dst      = '0;
    reads_rs = 1'b0;
    is_jump  = 1'b0;
    is_jreg  = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU: begin
            ctrl.reg_write = 1'b1;
            dst            = rd;
            reads_rs       = 1'b1;
            case (funct)
              FN_ADD:  ctrl.alu_op = ALU_ADD;
              FN_ADDU: ctrl.alu_op = ALU_ADDU;
              FN_SUB:  ctrl.alu_op = ALU_SUB;
              FN_SUBU: ctrl.alu_op = ALU_SUBU;
              FN_AND:  ctrl.alu_op = ALU_AND;
              FN_OR:   ctrl.alu_op = ALU_OR;
              FN_XOR:  ctrl.alu_op = ALU_XOR;
              FN_NOR:  ctrl.alu_op = ALU_NOR;
              FN_SLT:  ctrl.alu_op = ALU_SLT;
              default: ctrl.alu_op = ALU_SLTU;
            endcase
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src_a = 1'b1;
            dst            = rd;
            case (funct)
              FN_SLL:  ctrl.alu_op = ALU_SLL;
              FN_SRL:  ctrl.alu_op = ALU_SRL;
              default: ctrl.alu_op = ALU_SRA;
            endcase
          end
          FN_JR: begin
            is_jreg  = 1'b1;
            reads_rs = 1'b1;
          end
          FN_JALR: begin
            is_jreg         = 1'b1;
            reads_rs        = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = MTR_PC4;
            dst             = rd;
          end
          default: ;
        endcase
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = MTR_MEM;
        ctrl.alu_src_b  = 1'b1;
        ctrl.alu_op     = ALU_ADD;
        dst             = rt;
        reads_rs        = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        reads_rs       = 1'b1;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_op    = ALU_PASSB;
        dst            = rt;
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_SLTIU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        dst            = rt;
        reads_rs       = 1'b1;
        case (op)
          OP_ADDI:  ctrl.alu_op = ALU_ADD;
          OP_ADDIU: ctrl.alu_op = ALU_ADDU;
          OP_ANDI:  ctrl.alu_op = ALU_AND;
          OP_ORI:   ctrl.alu_op = ALU_OR;
          OP_SLTI:  ctrl.alu_op = ALU_SLT;
          default:  ctrl.alu_op = ALU_SLTU;
        endcase
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        ctrl.branch = 1'b1;
        reads_rs    = 1'b1;
        case (op)
          OP_BEQ:  ctrl.alu_op = BR_EQ;
          OP_BNE:  ctrl.alu_op = BR_NE;
          OP_BLEZ: ctrl.alu_op = BR_LEZ;
          default: ctrl.alu_op = BR_GTZ;
        endcase
      end
      OP_J: begin
        is_jump = 1'b1;
      end
      OP_JAL: begin
        is_jump         = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = MTR_PC4;
        dst             = 5'd31;
      end
      default: ;
    endcase
  end

  // rt is a true source only for R-type, sw and beq/bne
  assign rt_used = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);

  logic lu_stall;
  logic jr_stall;
  logic wb_stall;

  assign lu_stall = idex_q.ctrl.mem_read && (idex_q.dst != '0) &&
                    ((idex_q.dst == rs) || ((idex_q.dst == rt) && rt_used));

  // jr/jalr read rs in decode, so wait until its producer leaves EX and MEM
  assign jr_stall = is_jreg && (rs != '0) &&
                    ((idex_q.ctrl.reg_write && (idex_q.dst == rs)) ||
                     (mem_regwrite && (mem_dst == rs)));

`ifdef REGFILE_BYPASS_EN
  logic unused_reads_rs;
  assign unused_reads_rs = reads_rs;
  assign wb_stall        = 1'b0;
`else
  // No bypass: the register file only holds the new value after this edge
  assign wb_stall = wb_en && (wb_addr != '0) &&
                    ((reads_rs && (wb_addr == rs)) || (rt_used && (wb_addr == rt)));
`endif

  assign Stall = lu_stall || jr_stall || wb_stall;

  logic jump_ok;
  assign jump_ok  = !Stall && !nop;
  assign IDnop    = (is_jump || is_jreg) && jump_ok;
  assign PCSrc    = (is_jump && jump_ok) ? PC_JT  :
                    (is_jreg && jump_ok) ? PC_REG : PC_SEQ;
  assign JT       = instr[25:0];
  assign DatabusA = bus_a;

  // Assemble the decoded bundle
  always_comb begin
    idex_d       = '0;
    idex_d.pc4   = pc4;
    idex_d.bus_a = bus_a;
    idex_d.bus_b = bus_b;
    idex_d.imm   = ext_imm(op, instr[15:0]);
    idex_d.rs    = rs;
    idex_d.rt    = rt;
    idex_d.dst   = dst;
    idex_d.shamt = shamt;
    idex_d.ctrl  = ctrl;
  end

  // IDEX register: reset > flush bubble > stall bubble > decoded bundle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_q <= '0;
    end else if (nop) begin
      idex_q <= '0;
    end else if (Stall) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign IDEX = idex_q;

endmodule

// File: tb/tb_pipeline_id_stage.sv
// Directed testbench for pipeline_id_stage. Expectations adapt to whether
// REGFILE_BYPASS_EN is defined for the build.
module tb_pipeline_id_stage;

  logic          clk;
  logic          reset;
  logic [63:0]   IFID;
  logic          nop;
  logic          wb_en;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;
  logic          mem_regwrite;
  logic [4:0]    mem_dst;
  logic          Stall;
  logic          IDnop;
  logic [2:0]    PCSrc;
  logic [25:0]   JT;
  logic [31:0]   DatabusA;
  logic [159:0]  IDEX;

  int tests_run    = 0;
  int tests_failed = 0;

  pipeline_id_stage dut (
    .clk          (clk),
    .reset        (reset),
    .IFID         (IFID),
    .nop          (nop),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .mem_regwrite (mem_regwrite),
    .mem_dst      (mem_dst),
    .Stall        (Stall),
    .IDnop        (IDnop),
    .PCSrc        (PCSrc),
    .JT           (JT),
    .DatabusA     (DatabusA),
    .IDEX         (IDEX)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Instruction encoders
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ifid(input logic [31:0] pc4, input logic [31:0] instr);
    IFID = {pc4, instr};
    #1;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    wb_en   = 1'b1;
    wb_addr = addr;
    wb_data = data;
    tick();
    wb_en   = 1'b0;
    wb_addr = 5'd0;
    wb_data = 32'd0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (IDEX !== 160'd0) begin
      tests_failed++;
      $display("FAIL reset_idex: got %h expected 0", IDEX);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if (IDEX !== 160'd0 || Stall !== 1'b0 || PCSrc !== 3'd0 || IDnop !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: idex=%h stall=%b pcsrc=%0d idnop=%b expected all 0",
               IDEX, Stall, PCSrc, IDnop);
    end
    drive_ifid(32'h4, enc_i(6'h08, 5'd5, 5'd0, 16'h0000));
    tests_run++;
    if (DatabusA !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_read_r5: got %h expected 0", DatabusA);
    end
    drive_ifid(32'h0, 32'h0);
  endtask

  task automatic test_alu_op();
    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd5);
    drive_ifid(32'h1004, enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
    tests_run++;
    if (Stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL alu_no_stall: got %b expected 0", Stall);
    end
    tick();
    tests_run++;
    if (IDEX[127:96] !== 32'd7) begin
      tests_failed++;
      $display("FAIL alu_busA: got %h expected 7", IDEX[127:96]);
    end
    tests_run++;
    if (IDEX[95:64] !== 32'd5) begin
      tests_failed++;
      $display("FAIL alu_busB: got %h expected 5", IDEX[95:64]);
    end
    tests_run++;
    if (IDEX[21:17] !== 5'd3) begin
      tests_failed++;
      $display("FAIL alu_dst: got %0d expected 3", IDEX[21:17]);
    end
    // RegWrite only, ALUOp add = 0
    tests_run++;
    if (IDEX[11:0] !== 12'h800) begin
      tests_failed++;
      $display("FAIL alu_ctrl: got %h expected 800", IDEX[11:0]);
    end
    tests_run++;
    if (IDEX[159:128] !== 32'h1004) begin
      tests_failed++;
      $display("FAIL alu_pc4: got %h expected 1004", IDEX[159:128]);
    end
  endtask

  task automatic test_imm();
    drive_ifid(32'h2000, enc_i(6'h0c, 5'd1, 5'd8, 16'h8001));  // andi
    tick();
    tests_run++;
    if (IDEX[63:32] !== 32'h0000_8001 || IDEX[21:17] !== 5'd8) begin
      tests_failed++;
      $display("FAIL imm_andi: imm=%h dst=%0d expected 00008001 / 8", IDEX[63:32], IDEX[21:17]);
    end
    drive_ifid(32'h2004, enc_i(6'h08, 5'd1, 5'd8, 16'h8001));  // addi
    tick();
    tests_run++;
    if (IDEX[63:32] !== 32'hFFFF_8001) begin
      tests_failed++;
      $display("FAIL imm_addi: got %h expected ffff8001", IDEX[63:32]);
    end
    drive_ifid(32'h2008, enc_i(6'h0f, 5'd0, 5'd8, 16'h8001));  // lui
    tick();
    tests_run++;
    if (IDEX[63:32] !== 32'h8001_0000) begin
      tests_failed++;
      $display("FAIL imm_lui: got %h expected 80010000", IDEX[63:32]);
    end
    drive_ifid(32'h200c, enc_i(6'h2b, 5'd1, 5'd2, 16'h0010));  // sw
    tick();
    tests_run++;
    if (IDEX[21:17] !== 5'd0 || IDEX[11] !== 1'b0 || IDEX[9] !== 1'b1) begin
      tests_failed++;
      $display("FAIL sw_ctrl: dst=%0d regwrite=%b memwrite=%b expected 0/0/1",
               IDEX[21:17], IDEX[11], IDEX[9]);
    end
  endtask

  task automatic test_unknown();
    drive_ifid(32'h3000, enc_i(6'h3f, 5'd1, 5'd2, 16'h1234));
    tick();
    tests_run++;
    if (IDEX[11:0] !== 12'h000 || IDEX[21:17] !== 5'd0) begin
      tests_failed++;
      $display("FAIL unknown_op: ctrl=%h dst=%0d expected 000 / 0", IDEX[11:0], IDEX[21:17]);
    end
    drive_ifid(32'h3004, enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h3f));
    tick();
    tests_run++;
    if (IDEX[11:0] !== 12'h000) begin
      tests_failed++;
      $display("FAIL unknown_funct: ctrl=%h expected 000", IDEX[11:0]);
    end
  endtask

  task automatic test_load_use();
    int n;
    drive_ifid(32'h4000, enc_i(6'h23, 5'd0, 5'd4, 16'h0000));  // lw $4,0($0)
    tick();
    // RegWrite, MemRead, MemToReg=1, ALUSrcB
    tests_run++;
    if (IDEX[11:0] !== 12'hCA0) begin
      tests_failed++;
      $display("FAIL lw_ctrl: got %h expected ca0", IDEX[11:0]);
    end
    drive_ifid(32'h4004, enc_r(5'd4, 5'd4, 5'd5, 5'd0, 6'h20));  // add $5,$4,$4
    n = 0;
    while (Stall === 1'b1 && n < 5) begin
      n++;
      tick();
      if (n == 1) begin
        tests_run++;
        if (IDEX !== 160'd0) begin
          tests_failed++;
          $display("FAIL load_use_bubble: got %h expected 0", IDEX);
        end
      end
    end
    tests_run++;
    if (n != 1) begin
      tests_failed++;
      $display("FAIL load_use_stall_len: got %0d cycles expected 1", n);
    end
    tick();
    tests_run++;
    if (IDEX[21:17] !== 5'd5 || IDEX[31:27] !== 5'd4) begin
      tests_failed++;
      $display("FAIL load_use_add: dst=%0d rs=%0d expected 5 / 4", IDEX[21:17], IDEX[31:27]);
    end
  endtask

  task automatic test_jr();
    drive_ifid(32'h0, 32'h0);
    wb_write(5'd31, 32'h0000_0100);
    drive_ifid(32'h5000, enc_i(6'h08, 5'd0, 5'd31, 16'h0100));  // addi $31,$0,0x100
    tick();
    drive_ifid(32'h5004, enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));  // jr $31
    tests_run++;
    if (Stall !== 1'b1 || PCSrc !== 3'd0 || IDnop !== 1'b0) begin
      tests_failed++;
      $display("FAIL jr_stall_ex: stall=%b pcsrc=%0d idnop=%b expected 1/0/0", Stall, PCSrc, IDnop);
    end
    tick();
    mem_regwrite = 1'b1;
    mem_dst      = 5'd31;
    #1;
    tests_run++;
    if (Stall !== 1'b1 || PCSrc !== 3'd0) begin
      tests_failed++;
      $display("FAIL jr_stall_mem: stall=%b pcsrc=%0d expected 1/0", Stall, PCSrc);
    end
    tick();
    mem_regwrite = 1'b0;
    mem_dst      = 5'd0;
    #1;
    tests_run++;
    if (Stall !== 1'b0 || PCSrc !== 3'd3 || IDnop !== 1'b1) begin
      tests_failed++;
      $display("FAIL jr_resolve: stall=%b pcsrc=%0d idnop=%b expected 0/3/1", Stall, PCSrc, IDnop);
    end
    tests_run++;
    if (DatabusA !== 32'h0000_0100) begin
      tests_failed++;
      $display("FAIL jr_target: got %h expected 00000100", DatabusA);
    end
    tick();
  endtask

  task automatic test_jump();
    drive_ifid(32'h6004, enc_j(6'h02, 26'h0123456));  // j
    tests_run++;
    if (PCSrc !== 3'd2 || JT !== 26'h0123456 || IDnop !== 1'b1) begin
      tests_failed++;
      $display("FAIL j_resolve: pcsrc=%0d jt=%h idnop=%b expected 2/0123456/1", PCSrc, JT, IDnop);
    end
    tick();
    drive_ifid(32'h6008, enc_j(6'h03, 26'h0123456));  // jal
    tests_run++;
    if (PCSrc !== 3'd2 || IDnop !== 1'b1) begin
      tests_failed++;
      $display("FAIL jal_resolve: pcsrc=%0d idnop=%b expected 2/1", PCSrc, IDnop);
    end
    tick();
    // RegWrite, MemToReg = 2, dst = 31
    tests_run++;
    if (IDEX[11:0] !== 12'h900 || IDEX[21:17] !== 5'd31 || IDEX[159:128] !== 32'h6008) begin
      tests_failed++;
      $display("FAIL jal_idex: ctrl=%h dst=%0d pc4=%h expected 900/31/6008",
               IDEX[11:0], IDEX[21:17], IDEX[159:128]);
    end
  endtask

  task automatic test_flush();
    drive_ifid(32'h7000, enc_i(6'h23, 5'd0, 5'd4, 16'h0000));  // lw $4
    tick();
    // jal whose target bits [25:21] alias rs = 4, colliding with the load
    drive_ifid(32'h7004, enc_j(6'h03, 26'h0800000));
    tests_run++;
    if (Stall !== 1'b1 || PCSrc !== 3'd0) begin
      tests_failed++;
      $display("FAIL flush_pre_stall: stall=%b pcsrc=%0d expected 1/0", Stall, PCSrc);
    end
    nop = 1'b1;
    #1;
    tests_run++;
    if (Stall !== 1'b1 || PCSrc !== 3'd0 || IDnop !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_outputs: stall=%b pcsrc=%0d idnop=%b expected 1/0/0", Stall, PCSrc, IDnop);
    end
    tick();
    nop = 1'b0;
    tests_run++;
    if (IDEX !== 160'd0) begin
      tests_failed++;
      $display("FAIL flush_idex: got %h expected 0", IDEX);
    end
    drive_ifid(32'h0, 32'h0);
    tick();
  endtask

  task automatic test_bypass();
    wb_en   = 1'b1;
    wb_addr = 5'd6;
    wb_data = 32'h0000_DEAD;
    drive_ifid(32'h8004, enc_r(5'd6, 5'd0, 5'd7, 5'd0, 6'h25));  // or $7,$6,$0
`ifdef REGFILE_BYPASS_EN
    tests_run++;
    if (Stall !== 1'b0 || DatabusA !== 32'h0000_DEAD) begin
      tests_failed++;
      $display("FAIL bypass_read: stall=%b busA=%h expected 0/0000dead", Stall, DatabusA);
    end
    tick();
    wb_en = 1'b0;
    wb_addr = 5'd0;
    wb_data = 32'd0;
`else
    tests_run++;
    if (Stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL nobypass_stall: got %b expected 1", Stall);
    end
    tick();
    wb_en = 1'b0;
    wb_addr = 5'd0;
    wb_data = 32'd0;
    #1;
    tests_run++;
    if (Stall !== 1'b0 || IDEX !== 160'd0) begin
      tests_failed++;
      $display("FAIL nobypass_bubble: stall=%b idex=%h expected 0/0", Stall, IDEX);
    end
    tick();
`endif
    tests_run++;
    if (IDEX[127:96] !== 32'h0000_DEAD || IDEX[21:17] !== 5'd7) begin
      tests_failed++;
      $display("FAIL bypass_idex: busA=%h dst=%0d expected 0000dead/7", IDEX[127:96], IDEX[21:17]);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_ifid(32'h9000, enc_i(6'h23, 5'd0, 5'd4, 16'h0000));
    tick();
    drive_ifid(32'h9004, enc_r(5'd4, 5'd4, 5'd5, 5'd0, 6'h20));
    tests_run++;
    if (Stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_pre: stall=%b expected 1", Stall);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (Stall !== 1'b0 || IDEX !== 160'd0) begin
      tests_failed++;
      $display("FAIL midreset_clear: stall=%b idex=%h expected 0/0", Stall, IDEX);
    end
    drive_ifid(32'h9008, enc_i(6'h08, 5'd1, 5'd0, 16'h0000));
    tests_run++;
    if (DatabusA !== 32'd0) begin
      tests_failed++;
      $display("FAIL midreset_regfile: r1=%h expected 0", DatabusA);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b1;
    IFID         = 64'd0;
    nop          = 1'b0;
    wb_en        = 1'b0;
    wb_addr      = 5'd0;
    wb_data      = 32'd0;
    mem_regwrite = 1'b0;
    mem_dst      = 5'd0;
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    test_reset();
    test_alu_op();
    test_imm();
    test_unknown();
    test_load_use();
    test_jr();
    test_jump();
    test_flush();
    test_bypass();
    test_reset_mid_stall();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipeline_id_stage.md
# pipeline_id_stage

Instruction-decode stage of the five-stage pipeline CPU: consumes the 64-bit IFID bundle produced by the fetch stage, reads the register file, decodes control, and registers the 160-bit IDEX bundle for execute. It detects load-use and jump-register hazards and returns `Stall` to fetch. It also resolves `j`/`jal`/`jr`/`jalr` in decode, driving `PCSrc`, `JT` and `DatabusA` back to the PC logic.

## Interface
Parameters: none. Field layouts and encodings are fixed in the shared package.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; clears IDEX and the register file
- `IFID`  in  64  [63:32] PC+4 of the fetched instruction, [31:0] instruction word
- `nop`  in  1  flush from EX (taken branch); current decode is squashed
- `wb_en`  in  1  writeback enable
- `wb_addr`  in  5  writeback register
- `wb_data`  in  32  writeback data
- `mem_regwrite`  in  1  MEM-stage instruction writes a register
- `mem_dst`  in  5  MEM-stage destination register
- `Stall`  out  1  hold PC and IFID this cycle
- `IDnop`  out  1  jump taken in ID; top ORs this into fetch `nop` to kill the slot after the jump
- `PCSrc`  out  3  0 = PC+4, 2 = `JT`, 3 = `DatabusA`; branches (1) are resolved in EX, not here
- `JT`  out  26  instruction[25:0]
- `DatabusA`  out  32  rs read data (jr/jalr target)
- `IDEX`  out  160  [159:128] PC+4, [127:96] busA, [95:64] busB, [63:32] imm, [31:27] rs, [26:22] rt, [21:17] dst, [16:12] shamt, [11] RegWrite, [10] MemRead, [9] MemWrite, [8:7] MemToReg (0 = ALU, 1 = mem, 2 = PC+4), [6] ALUSrcA (shamt), [5] ALUSrcB (imm), [4] Branch, [3:0] ALUOp

## Operation
- **Decoded subset:**
  - R-type (op 0): add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr, jalr
  - I-type: lw 0x23, sw 0x2b, lui 0x0f, addi 0x08, addiu 0x09, andi 0x0c, ori 0x0d, slti 0x0a, sltiu 0x0b, beq 0x04, bne 0x05, blez 0x06, bgtz 0x07
  - J-type: j 0x02, jal 0x03
- **Unknown opcode or funct:** all ctrl bits are zero (acts as a bubble). No trap.
- **Immediate:**
  - andi and ori zero-extend.
  - lui places imm in bits [31:16] with zeros below.
  - All others sign-extend.
- **Destination (`dst`):**
  - R-type uses rd.
  - I-type loads and ALU ops use rt.
  - jal uses 31.
  - sw, branches, j and jr use 0, with RegWrite = 0.
- **jal/jalr:** RegWrite = 1 and MemToReg = 2.
- **Register file:**
  - 32×32; `$0` reads 0 and writes to it are ignored.
  - Written on the clock edge when `wb_en` is high.
  - Two combinational read ports on rs and rt.
- **Load-use stall:** `Stall` = IDEX.MemRead AND IDEX.dst ≠ 0 AND (dst == rs OR (dst == rt AND the instruction reads rt)).
  - The instruction reads rt for R-type, sw and beq/bne only.
- **jr/jalr stall:** `Stall` is also asserted when rs ≠ 0 and rs matches IDEX.dst (with IDEX.RegWrite) or matches `mem_dst` (with `mem_regwrite`).
- **Jumps:**
  - j/jal: `PCSrc` = 2.
  - jr/jalr: `PCSrc` = 3.
  - In both cases `IDnop` = 1, unless `Stall` or `nop` is high, in which case `PCSrc` = 0 and `IDnop` = 0.
- **IDEX update priority:** reset > `nop` (load all-zero bubble) > `Stall` (load bubble) > load the decoded bundle.

## Timing
- Reset values:
  - IDEX = 0.
  - All 32 registers = 0.
  - `Stall`, `IDnop`, `PCSrc` are 0 while IFID is 0 (sll $0 decodes as a harmless nop).
- Latency is 1 cycle from IFID to IDEX.
- `Stall`, `PCSrc`, `JT`, `DatabusA` and `IDnop` are combinational from IFID, IDEX state and the MEM inputs. There is no internal state besides IDEX and the register file.
- A load-use stall lasts exactly 1 cycle: the bubble clears IDEX.MemRead on the next cycle.
- A jr stall lasts until the producer has left both EX and MEM (2 cycles max behind an ALU op).
- If `nop` and `Stall` are high in the same cycle, the flush wins: a bubble is loaded and `Stall` is still driven. Fetch overrides the stall because of `nop`.
- Reset asserted mid-stall clears IDEX immediately (asynchronous); `Stall` falls in the same cycle.

## Configuration
- `REGFILE_BYPASS_EN` defined: a read whose address equals `wb_addr` with `wb_en` high and address ≠ 0 returns `wb_data` in the same cycle (write-then-read).
- `REGFILE_BYPASS_EN` undefined: there is no bypass, and `Stall` is additionally asserted whenever `wb_en` is high and `wb_addr` ≠ 0 matches a register the instruction reads.

## Structure
- **Shared package `pipeline_pkg`:** opcode and funct constants, ALUOp encodings, MemToReg and PCSrc encodings, and IDEX field bit positions.
- **Sub-module `pipeline_regfile`:** holds the register array and the optional bypass.
- Decode, hazard logic and the IDEX register stay in `pipeline_id_stage`.

## Test plan
- **Reset:** release reset with IFID = 0 → IDEX = 0, `Stall` = 0, `PCSrc` = 0; a read of $5 returns 0.
- **ALU op:** write $1 = 7 and $2 = 5 via WB, then IFID = add $3,$1,$2 → next cycle IDEX busA = 7, busB = 5, dst = 3, RegWrite = 1.
- **Load-use:** lw $4,0($0) followed by add $5,$4,$4 → `Stall` = 1 for exactly one cycle, a bubble enters IDEX, then the add is decoded.
- **jr:** jr $31 with IDEX writing $31 → `Stall` for 2 cycles, then `PCSrc` = 3, `DatabusA` = $31, `IDnop` = 1.
- **Flush:** `nop` = 1 with `Stall` = 1 and jal in IFID → IDEX = 0, `PCSrc` = 0, `IDnop` = 0.
- **Bypass:** `wb_en` = 1 with `wb_addr` = 6 and `wb_data` = 0xDEAD while decoding or $7,$6,$0 → with `REGFILE_BYPASS_EN`, busA = 0xDEAD and no stall; without it, `Stall` = 1 for one cycle and busA = 0xDEAD after.
